// File: rtl/memory_stage.sv
// ME stage: data-memory req/ack access, branch resolve, registered WB bundle. Optional ack watchdog: MEM_TIMEOUT_EN.
// Latency: 1 cycle to WB; a slow memory adds one bubble per cycle waited.
// Backpressure: stall_o freezes upstream while an access waits for dmem_ack_i.
module memory_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int PC_W    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rf_we_i,
  input  logic              mem_we_i,
  input  logic              mem2rf_i,
  input  logic              branch_i,
  input  logic              check_eq_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [ADDR_W-1:0] rf_waddr_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [PC_W-1:0]   pc_branch_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              stall_o,
  output logic              br_taken_o,
  output logic [PC_W-1:0]   pc_branch_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              err_o
);

  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("memory_stage: TIMEOUT must be >= 2");
  end

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state, state_nxt;

  logic              mem_op;
  logic              capture;
  logic              timeout;
  logic              wb_load;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;

  // Snapshot of the bundle that missed its ack; drives the bus while waiting.
  logic              h_we;
  logic              h_mem2rf;
  logic              h_rf_we;
  logic [ADDR_W-1:0] h_waddr;
  logic [DATA_W-1:0] h_alu;
  logic [DATA_W-1:0] h_wdata;

  assign mem_op      = mem_we_i | mem2rf_i;
  assign pc_branch_o = pc_branch_i;
  assign br_taken_o  = branch_i & (state == S_IDLE) & ((alu_result_i == '0) == check_eq_i);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign timeout = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign err_o   = err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (capture)
        wait_cnt <= '0;
      else if (state == S_WAIT && !dmem_ack_i)
        wait_cnt <= wait_cnt + 1'b1;
      if (state == S_WAIT && !dmem_ack_i && timeout)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    stall_o      = 1'b0;
    capture      = 1'b0;
    wb_load      = 1'b0;
    wb_we        = 1'b0;
    wb_waddr     = rf_waddr_i;
    wb_wdata     = alu_result_i;
    case (state)
      S_IDLE: begin
        dmem_req_o   = mem_op;
        dmem_we_o    = mem_we_i;
        dmem_addr_o  = ADDR_W'(alu_result_i);
        dmem_wdata_o = mem_wdata_i;
        if (mem_op && !dmem_ack_i) begin
          stall_o   = 1'b1;
          capture   = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          wb_load = 1'b1;
          wb_we   = rf_we_i;
          if (mem2rf_i)
            wb_wdata = dmem_rdata_i;
        end
      end
      S_WAIT: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = h_we;
        dmem_addr_o  = ADDR_W'(h_alu);
        dmem_wdata_o = h_wdata;
        if (dmem_ack_i) begin
          wb_load   = 1'b1;
          wb_we     = h_rf_we;
          wb_waddr  = h_waddr;
          wb_wdata  = h_mem2rf ? dmem_rdata_i : h_alu;
          state_nxt = S_IDLE;
        end else if (timeout) begin
          // Abandoned access: no writeback, upstream released this cycle.
          state_nxt = S_IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      h_we       <= 1'b0;
      h_mem2rf   <= 1'b0;
      h_rf_we    <= 1'b0;
      h_waddr    <= '0;
      h_alu      <= '0;
      h_wdata    <= '0;
    end else begin
      state   <= state_nxt;
      rf_we_o <= wb_load & wb_we;
      if (wb_load) begin
        rf_waddr_o <= wb_waddr;
        rf_wdata_o <= wb_wdata;
      end
      if (capture) begin
        h_we     <= mem_we_i;
        h_mem2rf <= mem2rf_i;
        h_rf_we  <= rf_we_i;
        h_waddr  <= rf_waddr_i;
        h_alu    <= alu_result_i;
        h_wdata  <= mem_wdata_i;
      end
    end
  end

endmodule
